apb_cfg_arbiter: RTL and testbench

- Shares one APB master port between NUM_REQ on-chip requesters: the boot-time MAC register loader, the runtime MDIO/PHY manager and the host debug bridge.
- Round-robin arbitration; runs the full APB setup/access handshake with pready/pslverr.
- Returns read data and error status to the granted requester.
- Sits between the requesters and the tsmac APB register slave, in the pclk domain.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/apb_cfg_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_apb_cfg_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg
//   Shared types and default sizes for apb_cfg_arbiter and its round-robin
//   arbiter. The timeout default only matters in builds that define
//   APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 3;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Searches req starting one position
//   after last_grant, wrapping around, and returns the first set bit.
// Ports:
//   req        in  N      pending requests
//   last_grant in  IDX_W  index granted last time
//   grant      out N      one-hot grant (all zero when nothing pending)
//   grant_idx  out IDX_W  index of the granted bit
//   any        out 1      at least one request pending
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    cand      = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    grant = '0;
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/apb_cfg_arbiter.sv
// apb_cfg_arbiter
//   Shares one APB master port between NUM_REQ requesters (MAC register
//   loader, MDIO/PHY manager, host debug bridge) using round-robin
//   arbitration, and returns read data / error status to the winner.
//   Optional build macro APB_ARB_TIMEOUT_EN adds an ACCESS-phase timeout of
//   TIMEOUT_CYC cycles; without it ACCESS waits for pready indefinitely.
// Ports:
//   pclk, presetn        clock, asynchronous active-high reset
//   req_valid/req_write  per-requester request and direction
//   req_addr/req_wdata   packed per-requester address and write data
//   req_ready            one-cycle accept pulse (one-hot)
//   rsp_valid            one-cycle completion pulse (one-hot)
//   rsp_rdata/rsp_err    read data and error, valid with rsp_valid
//   psel..pslverr        APB master port
//
// state  | meaning
// IDLE   | arbitrate; accept winner and capture its request
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready (or timeout)
// RESP   | completion pulse to the granted requester
module apb_cfg_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
`ifdef APB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  // Accept is combinational in IDLE so the requester sees it in the grant
  // cycle; gated by reset so nothing is accepted while the block is held.
  assign req_ready = (state_q == IDLE && !presetn) ? arb_grant : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d      = SETUP;
          last_grant_d = arb_idx;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          pwrite_d     = req_write[arb_idx];
          paddr_d      = addr_arr[arb_idx];
          pwdata_d     = req_write[arb_idx] ? wdata_arr[arb_idx] : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        // pready is tested first so a completion in the expiry cycle wins.
        if (pready) begin
          state_d                   = RESP;
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d               = pwrite_q ? '0 : prdata;
          rsp_err_d                 = pslverr;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d                   = RESP;
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_err_d                 = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        if (state_d == RESP) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          paddr_d   = '0;
          pwdata_d  = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cfg_arbiter.sv
// tb_apb_cfg_arbiter
//   Randomised and directed stimulus for apb_cfg_arbiter. Requesters pull
//   jobs from a shared list; an APB slave model answers with address-derived
//   wait states, data and errors. A timeline model predicts each grant, the
//   bus activity and the completion, and a monitor compares against it.
module tb_apb_cfg_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic            pclk = 1'b0;
  logic            presetn = 1'b0;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;

  apb_cfg_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef APB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    int          idx;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } job_t;

  typedef struct packed {
    int          idx;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          g;
    int          w;
    logic [31:0] rdata;
    bit          err;
  } txn_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  job_t  jobs[$];
  txn_t  exp_q[$];
  int    grants[$];
  bit    errs_log[$];
  txn_t  cur;
  bit    cur_act = 0;
  int    ptr = N - 1;
  int    free_cyc = 0;
  int    low_run = 2;
  bit    psel_prev = 0;
  bit    slv_stuck = 0;
  bit    rand_gap = 0;
  logic [N-1:0] ready_seen = '0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Slave behaviour is a pure function of the address.
  function automatic int waits_of(input logic [7:0] a);
    return int'(a[4:2]);
  endfunction
  function automatic logic [31:0] rdata_of(input logic [7:0] a);
    return (a == 8'h12) ? 32'h80 : {~a, a, a ^ 8'h5A, 8'hC3};
  endfunction
  function automatic logic err_of(input logic [7:0] a);
    return a[7:5] == 3'b111;
  endfunction

  task automatic add_job(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d);
    job_t j;
    j.idx = i; j.wr = wr; j.addr = a; j.wdata = d;
    jobs.push_back(j);
  endtask

  task automatic flush_model();
    exp_q.delete();
    cur_act   = 0;
    ptr       = N - 1;
    free_cyc  = 0;
    low_run   = 2;
    psel_prev = 0;
  endtask

  // APB slave
  initial begin
    int wcnt;
    wcnt = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(posedge pclk); #1;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      if (psel && penable && !slv_stuck) begin
        if (wcnt >= waits_of(paddr)) begin
          pready  = 1'b1;
          pslverr = err_of(paddr);
          prdata  = rdata_of(paddr);
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end else if (!psel) begin
        wcnt = 0;
      end
    end
  end

  // Requesters: hold a job until accepted, then load the next one.
  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(posedge pclk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && ready_seen[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && (!rand_gap || $urandom_range(0, 2) != 0)) begin
          for (int j = 0; j < jobs.size(); j++) begin
            if (jobs[j].idx == i) begin
              req_valid[i]              = 1'b1;
              req_write[i]              = jobs[j].wr;
              req_addr[i*AW +: AW]      = jobs[j].addr;
              req_wdata[i*DW +: DW]     = jobs[j].wdata;
              jobs.delete(j);
              break;
            end
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge pclk) begin : mon
    int e;
    logic [N-1:0] er;
    txn_t t;
    bit ep, epe;
    ready_seen = req_ready;
    if (presetn === 1'b0) begin
      // bus timeline of the current transaction
      ep  = cur_act && cyc >= cur.g + 1 && cyc <= cur.g + 2 + cur.w;
      epe = cur_act && cyc >= cur.g + 2 && cyc <= cur.g + 2 + cur.w;
      chk("psel", psel, ep);
      chk("penable", penable, epe);
      if (ep) begin
        chk("paddr", paddr, cur.addr);
        chk("pwrite", pwrite, cur.wr);
        chk("pwdata", pwdata, cur.wr ? cur.wdata : 32'h0);
      end else begin
        chk("pwdata_idle", pwdata, 0);
      end
      if (psel && !psel_prev) chk("psel_gap", low_run >= 2, 1'b1);
      low_run   = psel ? 0 : low_run + 1;
      psel_prev = psel;

      // expected grant: first pending requester after the last winner
      e = -1;
      if (cyc >= free_cyc)
        for (int k = 1; k <= N; k++)
          if (e < 0 && req_valid[(ptr + k) % N]) e = (ptr + k) % N;
      er = '0;
      if (e >= 0) er[e] = 1'b1;
      chk("req_ready", req_ready, er);
      if (e >= 0) begin
        t.idx   = e;
        t.wr    = req_write[e];
        t.addr  = req_addr[e*AW +: AW];
        t.wdata = req_wdata[e*DW +: DW];
        t.g     = cyc;
        if (slv_stuck) begin
`ifdef APB_ARB_TIMEOUT_EN
          t.w = TO - 1;
`else
          t.w = 1000000;
`endif
          t.rdata = '0;
          t.err   = 1'b1;
        end else begin
          t.w     = waits_of(t.addr);
          t.rdata = t.wr ? 32'h0 : rdata_of(t.addr);
          t.err   = err_of(t.addr);
        end
        exp_q.push_back(t);
        cur      = t;
        cur_act  = 1;
        ptr      = e;
        free_cyc = cyc + 4 + t.w;
        grants.push_back(e);
      end

      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          t = exp_q.pop_front();
          er = '0;
          er[t.idx] = 1'b1;
          chk("rsp_valid", rsp_valid, er);
          chk("rsp_rdata", rsp_rdata, t.rdata);
          chk("rsp_err", rsp_err, t.err);
          chk("rsp_cycle", cyc, t.g + 3 + t.w);
          errs_log.push_back(rsp_err);
        end
      end
      while (exp_q.size() > 0 && cyc > exp_q[0].g + 3 + exp_q[0].w) begin
        chk("rsp_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((jobs.size() != 0 || req_valid != '0 || exp_q.size() != 0) && n < budget) begin
      @(posedge pclk);
      n++;
    end
    chk("idle_timeout", n < budget, 1'b1);
    repeat (2) @(posedge pclk);
  endtask

  task automatic do_reset();
    @(posedge pclk); #2;
    presetn = 1'b1;
    flush_model();
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_order[6];
    exp_order = '{0, 1, 2, 0, 1, 2};
    presetn = 1'b1;
    // single write from req0, pending during reset
    add_job(0, 1'b1, 8'h01, 32'h7211);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_req_valid_held", req_valid[0], 1'b1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge pclk); #1 presetn = 1'b0;
    wait_idle(100);

    // read with 4 wait states
    add_job(1, 1'b0, 8'h12, 32'hDEAD_BEEF);
    wait_idle(100);

    // continuous contention from reset
    do_reset();
    grants.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        add_job(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom);
    wait_idle(300);
    chk("grant_count", grants.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < grants.size()) chk("grant_order", grants[k], exp_order[k]);

    // slave error then clean transaction
    errs_log.delete();
    add_job(2, 1'b1, 8'hE4, 32'h1234_5678);
    add_job(2, 1'b0, 8'h05, 32'h0);
    wait_idle(100);
    chk("err_count", errs_log.size(), 2);
    if (errs_log.size() == 2) begin
      chk("err_first", errs_log[0], 1'b1);
      chk("err_second", errs_log[1], 1'b0);
    end

    // reset during ACCESS
    add_job(0, 1'b0, 8'h1C, 32'hCAFE_F00D);
    n = 0;
    while (!penable && n < 20) begin @(negedge pclk); n++; end
    chk("penable_reached", penable, 1'b1);
    @(posedge pclk); #2;
    presetn = 1'b1;
    flush_model();
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_paddr", paddr, 0);
    chk("mid_rst_pwdata", pwdata, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    grants.delete();
    add_job(2, 1'b1, 8'h20, 32'h2);
    add_job(1, 1'b1, 8'h21, 32'h1);
    add_job(0, 1'b1, 8'h22, 32'h0);
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b0;
    wait_idle(100);
    chk("post_rst_first", (grants.size() > 0) ? grants[0] : -1, 0);

    // slave never answers
    slv_stuck = 1'b1;
    errs_log.delete();
    add_job(1, 1'b0, 8'h40, 32'h0);
`ifdef APB_ARB_TIMEOUT_EN
    wait_idle(100);
    chk("timeout_err", (errs_log.size() == 1) ? errs_log[0] : 1'b0, 1'b1);
    slv_stuck = 1'b0;
`else
    repeat (40) @(posedge pclk);
    @(negedge pclk);
    chk("stuck_psel", psel, 1'b1);
    chk("stuck_penable", penable, 1'b1);
    chk("stuck_no_rsp", errs_log.size(), 0);
    slv_stuck = 1'b0;
    do_reset();
`endif

    // random traffic with idle gaps
    rand_gap = 1'b1;
    for (int k = 0; k < 45; k++)
      add_job($urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), $urandom);
    wait_idle(3000);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
